// File: rtl/regfile_scoreboard.sv
// Parametrised register file with two read ports, a write/clear port, a pending
// scoreboard and a request-driven sweep that clears one entry per cycle.
module regfile_scoreboard #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 8,
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset_all,
    input  logic             we,
    input  logic             clr,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             rsv,
    input  logic [AW-1:0]    rsv_addr,
    input  logic [AW-1:0]    raddr_a,
    input  logic [AW-1:0]    raddr_b,
    input  logic             b_sel,
    input  logic [WIDTH-1:0] imm_b,
    output logic [WIDTH-1:0] rdata_a,
    output logic [WIDTH-1:0] rdata_b,
    output logic             busy_a,
    output logic             busy_b,
    input  logic             sweep_req,
    output logic             sweep_busy,
    output logic             sweep_done
);

    typedef enum logic {IDLE, SWEEP} state_t;

    state_t             state, state_n;
    logic [AW-1:0]      idx, idx_n;
    logic               done_n;
    logic [WIDTH-1:0]   regs [DEPTH];
    logic [DEPTH-1:0]   pending;

    logic               sweeping;
    logic               wr_en;
    logic               rsv_en;
    logic [WIDTH-1:0]   wr_val;

    // Out-of-range addresses and the hardwired zero register are never targets.
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return (int'(a) < DEPTH) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    assign sweeping   = (state == SWEEP);
    assign sweep_busy = sweeping;
    assign wr_en      = !sweeping && (we || clr) && addr_ok(waddr);
    assign rsv_en     = !sweeping && rsv && addr_ok(rsv_addr);
    assign wr_val     = clr ? '0 : wdata;

    always_comb begin
        state_n = state;
        idx_n   = idx;
        done_n  = 1'b0;
        case (state)
            IDLE: begin
                if (sweep_req) begin
                    state_n = SWEEP;
                    idx_n   = '0;
                end
            end
            SWEEP: begin
                if (idx == AW'(DEPTH - 1)) begin
                    state_n = IDLE;
                    idx_n   = '0;
                    done_n  = 1'b1;
                end else begin
                    idx_n = idx + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset_all) begin
        if (reset_all) begin
            state      <= IDLE;
            idx        <= '0;
            sweep_done <= 1'b0;
        end else begin
            state      <= state_n;
            idx        <= idx_n;
            sweep_done <= done_n;
        end
    end

    // A reservation is applied after the write so it wins on the same address.
    always_ff @(posedge clk or posedge reset_all) begin
        if (reset_all) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            pending <= '0;
        end else if (sweeping) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (idx == AW'(i)) begin
                    regs[i]    <= '0;
                    pending[i] <= 1'b0;
                end
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_en && (waddr == AW'(i))) begin
                    regs[i]    <= wr_val;
                    pending[i] <= 1'b0;
                end
                if (rsv_en && (rsv_addr == AW'(i))) begin
                    pending[i] <= 1'b1;
                end
            end
        end
    end

    logic [WIDTH-1:0] arr_a, arr_b;
    logic             pend_a, pend_b;
    logic             hit_a, hit_b;

    always_comb begin
        arr_a  = '0;
        arr_b  = '0;
        pend_a = 1'b0;
        pend_b = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (raddr_a == AW'(i)) begin
                arr_a  = regs[i];
                pend_a = pending[i];
            end
            if (raddr_b == AW'(i)) begin
                arr_b  = regs[i];
                pend_b = pending[i];
            end
        end
        if (!addr_ok(raddr_a)) begin
            arr_a  = '0;
            pend_a = 1'b0;
        end
        if (!addr_ok(raddr_b)) begin
            arr_b  = '0;
            pend_b = 1'b0;
        end
    end

    // Forwarding presents the value being written; busy then reflects only a same-cycle reservation.
    always_comb begin
        hit_a   = (BYPASS != 0) && wr_en && (waddr == raddr_a);
        hit_b   = (BYPASS != 0) && wr_en && (waddr == raddr_b);
        rdata_a = hit_a ? wr_val : arr_a;
        busy_a  = hit_a ? (rsv_en && (rsv_addr == raddr_a)) : pend_a;
        rdata_b = imm_b;
        busy_b  = 1'b0;
        if (b_sel) begin
            rdata_b = hit_b ? wr_val : arr_b;
            busy_b  = hit_b ? (rsv_en && (rsv_addr == raddr_b)) : pend_b;
        end
    end

endmodule

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Parametrised general-purpose register file for the single-cycle datapath, succeeding the fixed 8x8 register bank. It provides two combinational read ports with an immediate mux on port B, one write/clear port, and optional write-through bypass and hardwired-zero register 0. A per-register pending scoreboard marks registers awaiting a result, and a synchronous sweep FSM clears the whole file one entry per cycle under a request/busy/done handshake.

## Interface
- WIDTH, 8, data width in bits
- DEPTH, 8, number of registers (>=2); AW = $clog2(DEPTH) address bits (localparam)
- ZERO_REG, 0, 1: register 0 reads as 0, never pending, writes/reserves to it ignored
- BYPASS, 1, 1: same-cycle write data forwarded to read ports
- clk  input  1  clock, all state updates on rising edge
- reset_all  input  1  reset, asynchronous, active-high
- we  input  1  write wdata into waddr
- clr  input  1  clear register waddr to 0
- waddr  input  AW  write/clear address
- wdata  input  WIDTH  write data
- rsv  input  1  set pending bit of rsv_addr
- rsv_addr  input  AW  reservation address
- raddr_a  input  AW  port A read address
- raddr_b  input  AW  port B read address
- b_sel  input  1  1: rdata_b = register; 0: rdata_b = imm_b
- imm_b  input  WIDTH  immediate for port B
- rdata_a  output  WIDTH  port A data (combinational)
- rdata_b  output  WIDTH  port B data (combinational)
- busy_a  output  1  pending[raddr_a]
- busy_b  output  1  pending[raddr_b] & b_sel
- sweep_req  input  1  start clear sweep (level sampled in IDLE)
- sweep_busy  output  1  sweep in progress
- sweep_done  output  1  one-cycle pulse at sweep end

## Operation
- Storage: DEPTH x WIDTH array plus DEPTH pending bits.
- Write port priority per cycle: clr over we; clr writes 0. Either one clears pending[waddr].
- rsv sets pending[rsv_addr]; if same cycle as we/clr to same address, rsv wins (pending ends 1), data still written.
- Reads: rdata_a = reg[raddr_a]; rdata_b = b_sel ? reg[raddr_b] : imm_b.
- BYPASS=1: if we|clr and waddr equals a read address, that port returns the value being written (0 for clr) in the same cycle; busy for that port reads 0 unless rsv also targets it. BYPASS=0: arrays-only read, new value visible next cycle.
- ZERO_REG=1: address 0 reads 0, busy 0, writes/clr/rsv to 0 have no effect.
- Address >= DEPTH (non-power-of-2 DEPTH): writes/rsv ignored, reads return 0, busy 0.
- FSM states IDLE, SWEEP. IDLE & sweep_req -> SWEEP, idx=0. SWEEP: each cycle reg[idx]<=0, pending[idx]<=0, idx++; after idx=DEPTH-1 -> IDLE with sweep_done=1 for that next cycle.
- During SWEEP: we, clr, rsv, sweep_req ignored; reads serve current array contents (partially cleared), bypass inactive.

## Timing
- reset_all (async): all registers 0, all pending 0, state IDLE, idx 0, sweep_busy 0, sweep_done 0; rdata_a/b then 0 (rdata_b = imm_b if b_sel=0), busy_a/b 0.
- Write latency: 1 cycle to array; 0 cycles to read ports with BYPASS=1.
- Sweep: sweep_busy rises the cycle after sweep_req sampled, stays high exactly DEPTH cycles; sweep_done high the cycle after sweep_busy falls; next sweep_req accepted in that same cycle (sweep_done and new start may coincide).
- reset_all mid-sweep: immediate return to IDLE, whole file zeroed, no sweep_done.
- Pending bits change only on clock edges; busy outputs are combinational on addresses.

## Test plan
- Reset then read all addresses -> rdata_a=0, busy_a=0; b_sel=0, imm_b=8'h5A -> rdata_b=8'h5A.
- we waddr=3 wdata=8'hC3 with raddr_a=3, BYPASS=1 -> rdata_a=8'hC3 same cycle; BYPASS=0 -> old 0 that cycle, 8'hC3 next.
- rsv 5 -> next cycle busy_a=1 at raddr_a=5; we 5 wdata=8'h11 -> next cycle busy_a=0, rdata=8'h11; rsv+we to 5 same cycle -> busy stays 1.
- clr and we same cycle to addr 2 with wdata=8'hFF -> reg2=0, pending2=0.
- ZERO_REG=1: we 0 wdata=8'hAA, rsv 0 -> rdata_a=0, busy_a=0 afterwards.
- Fill all regs with 8'hFF, pulse sweep_req -> sweep_busy high DEPTH=8 cycles, writes during sweep ignored, sweep_done one cycle, all regs 0; repeat with reset_all at cycle 4 -> no sweep_done, all regs 0.
